// File: rtl/mult_accum.sv
// Accumulates signed products from booth_mult (one per rising edge of done) into a
// saturating accumulator and presents the sum on a valid/ready handshake.
module mult_accum #(
    parameter int width     = 8,
    parameter int acc_width = 24,
    parameter int cnt_width = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [cnt_width-1:0]   len,
    input  logic                   mult_done,
    input  logic [2*width-1:0]     mult_M,
    output logic                   busy,
    output logic                   acc_valid,
    input  logic                   out_ready,
    output logic [acc_width-1:0]   acc_out,
    output logic                   sat_flag
);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    localparam logic [acc_width-1:0] ACC_MAX = {1'b0, {(acc_width-1){1'b1}}};
    localparam logic [acc_width-1:0] ACC_MIN = {1'b1, {(acc_width-1){1'b0}}};

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_done_d;
    logic                   w_capture;
    logic [cnt_width-1:0]   r_cnt;
    logic [acc_width-1:0]   r_acc;
    logic                   r_sat;
    logic                   r_busy;
    logic                   r_valid;
    logic [acc_width:0]     w_sum;
    logic                   w_ovf;
    logic [acc_width-1:0]   w_sat_val;

    assign w_capture = mult_done & ~r_done_d;

    // One guard bit: overflow shows as disagreement between the top two sum bits.
    always_comb begin
        w_sum     = {r_acc[acc_width-1], r_acc}
                  + {{(acc_width+1-2*width){mult_M[2*width-1]}}, mult_M};
        w_ovf     = w_sum[acc_width] ^ w_sum[acc_width-1];
        w_sat_val = w_sum[acc_width-1:0];
        if (w_ovf) begin
            w_sat_val = w_sum[acc_width] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (len == '0) ? OUT : ACCUM;
            ACCUM:   if (w_capture && (r_cnt == cnt_width'(1))) w_next = OUT;
            OUT:     if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Status outputs are registered from the next state so they align with r_state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sat    <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_done_d <= 1'b1;
        end else begin
            r_done_d <= mult_done;
            r_busy   <= (w_next != IDLE);
            r_valid  <= (w_next == OUT);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc <= '0;
                        r_sat <= 1'b0;
                        r_cnt <= len;
                    end
                end
                ACCUM: begin
                    if (w_capture) begin
                        r_acc <= w_sat_val;
                        r_cnt <= r_cnt - cnt_width'(1);
                        if (w_ovf) r_sat <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign acc_valid = r_valid;
    assign acc_out   = r_acc;
    assign sat_flag  = r_sat;

endmodule
